// File: rtl/encoder_pkg.sv
// Package for the rotary-encoder input conditioner.
// Holds the event codes delivered to the consumer, the quadrature state
// constants, and a helper that classifies a change between two debounced
// {A,B} states as a clockwise step, a counter-clockwise step, or an
// illegal double-bit jump.
package encoder_pkg;

  typedef enum logic [1:0] {
    EVT_NONE  = 2'b00,
    EVT_CW    = 2'b01,
    EVT_CCW   = 2'b10,
    EVT_PRESS = 2'b11
  } event_code_t;

  // Quadrature states as {A,B}. The clockwise Gray order is 11 -> 01 -> 00 -> 10 -> 11.
  localparam logic [1:0] QUAD_11 = 2'b11;
  localparam logic [1:0] QUAD_01 = 2'b01;
  localparam logic [1:0] QUAD_00 = 2'b00;
  localparam logic [1:0] QUAD_10 = 2'b10;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_CW,
    STEP_CCW,
    STEP_DOUBLE
  } quad_step_t;

  function automatic quad_step_t quad_step(input logic [1:0] prev, input logic [1:0] cur);
    quad_step_t s;
    s = STEP_NONE;
    if (prev != cur) begin
      if ((prev ^ cur) == 2'b11) begin
        s = STEP_DOUBLE;
      end else if ((prev == QUAD_11 && cur == QUAD_01) ||
                   (prev == QUAD_01 && cur == QUAD_00) ||
                   (prev == QUAD_00 && cur == QUAD_10) ||
                   (prev == QUAD_10 && cur == QUAD_11)) begin
        s = STEP_CW;
      end else begin
        s = STEP_CCW;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchronizer followed by a stability counter for one raw input.
// Ports:
//   clk    - sole clock, rising edge
//   reset  - synchronous, active-high; synchronizer and output go to 1
//   raw    - asynchronous raw input (idle high)
//   level  - debounced level
// The counter restarts whenever the synchronized value agrees with the
// current output. The output follows the synchronized value only after it
// has disagreed for DEBOUNCE_CYCLES consecutive cycles.
module debounce_filter #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             level_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      level_reg <= 1'b1;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        level_reg <= sync2_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign level = level_reg;

endmodule

// File: rtl/encoder_input_conditioner.sv
// Conditions a mechanical rotary encoder (quadrature A/B plus push switch).
// Ports:
//   clk, reset             - sole clock; synchronous active-high reset
//   encoder_clk/dt/sw      - raw asynchronous A, B (idle high) and switch (active low)
//   position               - signed detent count, wraps modulo 2^POS_WIDTH
//   sw_level               - debounced switch, 1 = pressed
//   event_valid/ready/code - event queue head: 01 CW, 10 CCW, 11 press
//   overflow               - sticky, set when an event was dropped on a full queue
module encoder_input_conditioner
  import encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int POS_WIDTH       = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 encoder_clk,
  input  logic                 encoder_dt,
  input  logic                 encoder_sw,
  output logic [POS_WIDTH-1:0] position,
  output logic                 sw_level,
  output logic                 event_valid,
  input  logic                 event_ready,
  output logic [1:0]           event_code,
  output logic                 overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW-1:0] LAST_PTR   = AW'(FIFO_DEPTH - 1);
  localparam logic [AW:0]   DEPTH_CNT  = (AW + 1)'(FIFO_DEPTH);

  // ---------------------------------------------------------------
  // Input conditioning: bit 0 = A, bit 1 = B, bit 2 = switch
  // ---------------------------------------------------------------
  logic [2:0] raw_vec;
  logic [2:0] db_vec;

  assign raw_vec = {encoder_sw, encoder_dt, encoder_clk};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_db
      debounce_filter #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
        .clk  (clk),
        .reset(reset),
        .raw  (raw_vec[gi]),
        .level(db_vec[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------
  // Quadrature decoding
  // ---------------------------------------------------------------
  logic [1:0] quad_cur;
  logic [1:0] quad_prev_reg;
  logic [2:0] acc_reg;
  logic [2:0] acc_next;
  logic [3:0] acc_sum;
  logic       det_cw_reg;
  logic       det_ccw_reg;
  logic       det_cw_next;
  logic       det_ccw_next;
  quad_step_t step;

  assign quad_cur = {db_vec[0], db_vec[1]};

  // The sum is formed one bit wider than the accumulator so a full
  // four-step rotation reads as +4 / -4 instead of wrapping.
  always_comb begin
    step         = quad_step(quad_prev_reg, quad_cur);
    acc_sum      = {acc_reg[2], acc_reg} + ((step == STEP_CW) ? 4'b0001 : 4'b1111);
    acc_next     = acc_reg;
    det_cw_next  = 1'b0;
    det_ccw_next = 1'b0;
    case (step)
      STEP_DOUBLE: acc_next = 3'b000;
      STEP_CW, STEP_CCW: begin
        if (quad_cur == QUAD_11) begin
          det_cw_next  = (acc_sum == 4'b0100);
          det_ccw_next = (acc_sum == 4'b1100);
          acc_next     = 3'b000;
        end else begin
          acc_next = acc_sum[2:0];
        end
      end
      default: acc_next = acc_reg;
    endcase
  end

  logic [POS_WIDTH-1:0] position_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      quad_prev_reg <= QUAD_11;
      acc_reg       <= 3'b000;
      det_cw_reg    <= 1'b0;
      det_ccw_reg   <= 1'b0;
      position_reg  <= '0;
    end else begin
      quad_prev_reg <= quad_cur;
      acc_reg       <= acc_next;
      det_cw_reg    <= det_cw_next;
      det_ccw_reg   <= det_ccw_next;
      if (det_cw_reg) begin
        position_reg <= position_reg + 1'b1;
      end else if (det_ccw_reg) begin
        position_reg <= position_reg - 1'b1;
      end
    end
  end

  assign position = position_reg;

  // ---------------------------------------------------------------
  // Switch press detection and event arbitration
  // ---------------------------------------------------------------
  logic        sw_prev_reg;
  logic        press_edge;
  logic        press_pending_reg;
  logic        press_pending_next;
  logic        push;
  event_code_t push_code;

  assign sw_level   = ~db_vec[2];
  assign press_edge = sw_level & ~sw_prev_reg;

  // Detents always win the push slot; a press waits in press_pending_reg
  // until a cycle without a detent, so it lands behind a simultaneous detent.
  always_comb begin
    push               = 1'b0;
    push_code          = EVT_NONE;
    press_pending_next = press_pending_reg | press_edge;
    if (det_cw_reg) begin
      push      = 1'b1;
      push_code = EVT_CW;
    end else if (det_ccw_reg) begin
      push      = 1'b1;
      push_code = EVT_CCW;
    end else if (press_pending_reg) begin
      push               = 1'b1;
      push_code          = EVT_PRESS;
      press_pending_next = press_edge;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_prev_reg       <= 1'b0;
      press_pending_reg <= 1'b0;
    end else begin
      sw_prev_reg       <= sw_level;
      press_pending_reg <= press_pending_next;
    end
  end

  // ---------------------------------------------------------------
  // Event queue
  // ---------------------------------------------------------------
  logic [1:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          overflow_reg;
  logic          full;
  logic          pop;
  logic          push_ok;

  assign full    = (count_reg == DEPTH_CNT);
  assign pop     = event_valid && event_ready;
  // A pop frees the slot in the same cycle, so a full queue still accepts.
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_reg] <= push_code;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
      end
      if (push_ok && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (!push_ok && pop) begin
        count_reg <= count_reg - 1'b1;
      end
      if (push && !push_ok) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign event_valid = (count_reg != '0);
  assign event_code  = event_valid ? fifo_mem[rd_ptr_reg] : EVT_NONE;
  assign overflow    = overflow_reg;

endmodule
